// File: rtl/lpf_pkg.sv
// lpf_pkg: shared defaults and the level-width helper for the decimating FIFO.
package lpf_pkg;
    localparam int DW_DEF    = 8;
    localparam int DECIM_DEF = 2;
    localparam int DEPTH_DEF = 8;
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/lpf_decim_fifo_if.sv
// lpf_decim_fifo_if: sample input, FWFT output handshake and status of the decimating FIFO.
interface lpf_decim_fifo_if
    import lpf_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    logic [DW-1:0]           din;
    logic                    din_vld;
    logic [DW-1:0]           dout;
    logic                    dout_vld;
    logic                    dout_rdy;
    logic [lvl_w(DEPTH)-1:0] level;
    logic                    ovf;
    logic                    ovf_clr;
    modport master(output din, din_vld, dout_rdy, ovf_clr, input dout, dout_vld, level, ovf);
    modport slave(input din, din_vld, dout_rdy, ovf_clr, output dout, dout_vld, level, ovf);
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through FIFO; a push while full is only taken
// when a pop frees the slot in the same cycle.
module sync_fifo_fwft
    import lpf_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int LW   = lvl_w(DEPTH),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          wr, rd;
    assign wr = push && (!full || pop);
    assign rd = pop && !empty;
    always_comb begin
        wr_d  = wr ? wr_q + 1'b1 : wr_q;
        rd_d  = rd ? rd_q + 1'b1 : rd_q;
        lvl_d = (wr && !rd) ? lvl_q + 1'b1 : (rd && !wr) ? lvl_q - 1'b1 : lvl_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end
    // Storage is deliberately not reset; the empty mux below hides stale entries.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_q] <= din;
    end
    assign empty = lvl_q == '0;
    assign full  = lvl_q == LW'(DEPTH);
    assign level = lvl_q;
    assign dout  = empty ? '0 : mem[rd_q];
endmodule

// File: rtl/lpf_decim_fifo.sv
// lpf_decim_fifo: keeps every DECIM-th valid LPF sample and buffers it in a FWFT FIFO
// with a sticky overflow flag for samples dropped while full.
module lpf_decim_fifo
    import lpf_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DECIM = DECIM_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic              clk,
    input logic              rst_n,
    lpf_decim_fifo_if.slave  bus
);
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
    logic [PW-1:0] phase_q, phase_d;
    logic          ovf_q, ovf_d;
    logic          last, keep, pop, empty, full;
    assign last = phase_q == PW'(DECIM - 1);
    assign keep = bus.din_vld && last;
    assign pop  = !empty && bus.dout_rdy;
    // Overflow set takes priority over a simultaneous clear.
    always_comb begin
        phase_d = bus.din_vld ? (last ? '0 : phase_q + 1'b1) : phase_q;
        ovf_d   = (keep && full && !pop) || (ovf_q && !bus.ovf_clr);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end
    sync_fifo_fwft #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep),
        .pop   (pop),
        .din   (bus.din),
        .dout  (bus.dout),
        .empty (empty),
        .full  (full),
        .level (bus.level)
    );
    assign bus.dout_vld = !empty;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_lpf_decim_fifo.sv
// tb_lpf_decim_fifo: directed scenarios plus random traffic against a queue-based model
// of decimation, FIFO occupancy and the sticky overflow flag.
module tb_lpf_decim_fifo;
    localparam int DECIM = 2;
    localparam int DEPTH = 8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] mq[$];
    int         vcnt;
    logic       m_ovf;
    logic [13:0] act;

    lpf_decim_fifo_if #(.DW(8), .DEPTH(DEPTH)) b();
    lpf_decim_fifo #(.DW(8), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;
    assign act = {b.dout_vld, b.dout, b.level, b.ovf};

    function automatic logic [13:0] exp_vec();
        int n = mq.size();
        return {n != 0, n != 0 ? mq[0] : 8'd0, 4'(n), m_ovf};
    endfunction

    task automatic model_clr();
        mq.delete();
        vcnt = 0;
        m_ovf = 1'b0;
    endtask

    // Drive one cycle, advance the model on the edge, return 1 ns after it.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        logic pop, drop;
        b.din = d;
        b.din_vld = v;
        b.dout_rdy = r;
        b.ovf_clr = c;
        @(posedge clk);
        pop = mq.size() != 0 && r;
        drop = 1'b0;
        if (pop) void'(mq.pop_front());
        if (v) begin
            vcnt++;
            if (vcnt % DECIM == 0) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else drop = 1'b1;
            end
        end
        m_ovf = drop ? 1'b1 : (c ? 1'b0 : m_ovf);
        #1;
    endtask

    task automatic pulse_rst();
        rst_n = 1'b0;
        model_clr();
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        b.din = 8'hAA;
        b.din_vld = 1'b1;
        b.dout_rdy = 1'b0;
        b.ovf_clr = 1'b0;
        model_clr();
        @(posedge clk);
        #1;
        total++;
        if (act !== 14'd0) begin
            $display("FAIL reset_state got=%h want=%h", act, 14'd0);
            bad++;
        end
        rst_n = 1'b1;
        step(1'b0, 8'd0, 1'b0, 1'b0);
        total++;
        if (act !== exp_vec()) begin
            $display("FAIL reset_release got=%h want=%h", act, exp_vec());
            bad++;
        end
    endtask

    task automatic test_ramp();
        int k = 0;
        pulse_rst();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(5 * i), 1'b1, 1'b0);
            total++;
            if (act !== exp_vec()) begin
                $display("FAIL ramp_model i=%0d got=%h want=%h", i, act, exp_vec());
                bad++;
            end
            total++;
            if (b.dout_vld !== 1'(i % 2)) begin
                $display("FAIL ramp_vld i=%0d got=%b want=%b", i, b.dout_vld, 1'(i % 2));
                bad++;
            end
            if (b.dout_vld) begin
                total++;
                if (b.dout !== 8'(5 + 10 * k)) begin
                    $display("FAIL ramp_dout k=%0d got=%0d want=%0d", k, b.dout, 5 + 10 * k);
                    bad++;
                end
                k++;
            end
        end
        total++;
        if (k != 8) begin
            $display("FAIL ramp_count got=%0d want=8", k);
            bad++;
        end
    endtask

    task automatic test_overflow();
        pulse_rst();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(5 * i), 1'b0, 1'b0);
            total++;
            if (act !== exp_vec()) begin
                $display("FAIL ovf_model i=%0d got=%h want=%h", i, act, exp_vec());
                bad++;
            end
            if (i == 15) begin
                total++;
                if (b.level !== 4'd8 || b.ovf !== 1'b0) begin
                    $display("FAIL ovf_full got=%0d/%b want=8/0", b.level, b.ovf);
                    bad++;
                end
            end
            if (i == 17) begin
                total++;
                if (b.level !== 4'd8 || b.ovf !== 1'b1) begin
                    $display("FAIL ovf_drop got=%0d/%b want=8/1", b.level, b.ovf);
                    bad++;
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (b.dout !== 8'(5 + 10 * k) || b.dout_vld !== 1'b1) begin
                $display("FAIL ovf_drain k=%0d got=%0d want=%0d", k, b.dout, 5 + 10 * k);
                bad++;
            end
            step(1'b0, 8'd0, 1'b1, 1'b0);
        end
        total++;
        if (b.level !== 4'd0 || b.dout_vld !== 1'b0 || b.dout !== 8'd0) begin
            $display("FAIL ovf_empty got=%0d/%b/%0d want=0/0/0", b.level, b.dout_vld, b.dout);
            bad++;
        end
    endtask

    task automatic test_full_pushpop();
        pulse_rst();
        for (int i = 0; i < 17; i++) step(1'b1, 8'(5 * i), 1'b0, 1'b0);
        step(1'b1, 8'd85, 1'b1, 1'b0);
        total++;
        if (b.level !== 4'd8 || b.ovf !== 1'b0) begin
            $display("FAIL full_pushpop got=%0d/%b want=8/0", b.level, b.ovf);
            bad++;
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (b.dout !== 8'(15 + 10 * k)) begin
                $display("FAIL full_drain k=%0d got=%0d want=%0d", k, b.dout, 15 + 10 * k);
                bad++;
            end
            step(1'b0, 8'd0, 1'b1, 1'b0);
        end
        total++;
        if (act !== exp_vec()) begin
            $display("FAIL full_end got=%h want=%h", act, exp_vec());
            bad++;
        end
    endtask

    task automatic test_vld_toggle();
        int k = 0;
        pulse_rst();
        for (int i = 0; i < 16; i++) begin
            step(1'(i % 2 == 0), 8'(i), 1'b1, 1'b0);
            total++;
            if (act !== exp_vec()) begin
                $display("FAIL toggle_model i=%0d got=%h want=%h", i, act, exp_vec());
                bad++;
            end
            if (b.dout_vld) begin
                total++;
                if (b.dout !== 8'(2 + 4 * k)) begin
                    $display("FAIL toggle_dout k=%0d got=%0d want=%0d", k, b.dout, 2 + 4 * k);
                    bad++;
                end
                k++;
            end
        end
        total++;
        if (k != 4) begin
            $display("FAIL toggle_count got=%0d want=4", k);
            bad++;
        end
    endtask

    task automatic test_async_reset();
        pulse_rst();
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0);
        total++;
        if (b.level !== 4'd5) begin
            $display("FAIL arst_pre got=%0d want=5", b.level);
            bad++;
        end
        rst_n = 1'b0;
        model_clr();
        #1;
        total++;
        if (act !== 14'd0) begin
            $display("FAIL arst_now got=%h want=%h", act, 14'd0);
            bad++;
        end
        #2 rst_n = 1'b1;
        step(1'b1, 8'd100, 1'b1, 1'b0);
        total++;
        if (b.dout_vld !== 1'b0) begin
            $display("FAIL arst_first got=%b want=0", b.dout_vld);
            bad++;
        end
        step(1'b1, 8'd101, 1'b1, 1'b0);
        total++;
        if (b.dout_vld !== 1'b1 || b.dout !== 8'd101) begin
            $display("FAIL arst_second got=%b/%0d want=1/101", b.dout_vld, b.dout);
            bad++;
        end
    endtask

    task automatic test_ovf_clr();
        pulse_rst();
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'd77, 1'b0, 1'b1);
        total++;
        if (b.ovf !== 1'b1 || b.level !== 4'd8) begin
            $display("FAIL clr_set_wins got=%b/%0d want=1/8", b.ovf, b.level);
            bad++;
        end
        step(1'b0, 8'd0, 1'b0, 1'b1);
        total++;
        if (b.ovf !== 1'b0) begin
            $display("FAIL clr_idle got=%b want=0", b.ovf);
            bad++;
        end
    endtask

    task automatic test_random();
        logic v, r, c;
        pulse_rst();
        for (int i = 0; i < 600; i++) begin
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 9) < ((i / 100) % 3) * 4 + 1;
            c = $urandom_range(0, 15) == 0;
            step(v, 8'($urandom), r, c);
            total++;
            if (act !== exp_vec()) begin
                $display("FAIL random i=%0d got=%h want=%h", i, act, exp_vec());
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_overflow();
        test_full_pushpop();
        test_vld_toggle();
        test_async_reset();
        test_ovf_clr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lpf_decim_fifo.md
LPF_DECIM_FIFO -- requirements
Module: lpf_decim_fifo

Interface
REQ-001 Parameter: DW, 8, sample width; matches the 3-tap LPF output width.
REQ-002 Parameter: DECIM, 2, decimation ratio; legal range 1..16.
REQ-003 Parameter: DEPTH, 8, FIFO entries; power of two, 2..64.
REQ-004 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: din, input, DW, filtered sample taken directly from the LPF dout.
REQ-007 Port: din_vld, input, 1, sample qualifier; tie to 1 when the upstream stage runs every clock.
REQ-008 Port: dout, output, DW, FIFO head sample (first-word fall-through).
REQ-009 Port: dout_vld, output, 1, head sample is valid.
REQ-010 Port: dout_rdy, input, 1, consumer accepts the head sample.
REQ-011 Port: level, output, $clog2(DEPTH+1), current FIFO occupancy.
REQ-012 Port: ovf, output, 1, sticky flag indicating a decimated sample was dropped.
REQ-013 Port: ovf_clr, input, 1, synchronous clear of ovf.

Function
REQ-014 The phase counter (0..DECIM-1) SHALL advance only on cycles with din_vld=1 and wrap from DECIM-1 to 0.
REQ-015 A sample SHALL be kept (push) when din_vld=1 and phase==DECIM-1; other valid samples are discarded; DECIM=1 keeps every valid sample.
REQ-016 Pop SHALL occur when dout_vld=1 and dout_rdy=1.
REQ-017 dout_vld SHALL equal (level!=0); dout SHALL present the oldest entry, and SHALL hold stable while dout_vld=1 and dout_rdy=0.
REQ-018 Latency: a sample pushed at edge k SHALL be visible on dout with dout_vld=1 immediately after edge k when the FIFO was empty (one registered stage, no combinational din->dout path).
REQ-019 Push when level==DEPTH without a simultaneous pop: the sample is dropped, FIFO contents and level are unchanged, ovf is set at that edge.
REQ-020 Push and pop in the same cycle at level==DEPTH: both are accepted, level stays at DEPTH, ovf is not set.
REQ-021 Push and pop in the same cycle at 0<level<DEPTH: level is unchanged and ordering is preserved.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.
REQ-023 ovf_clr=1 SHALL clear ovf; if an overflow occurs in the same cycle, set wins and ovf=1.
REQ-024 Data SHALL pass through unmodified (no rounding, no sign extension).

Reset
REQ-025 rst_n=0 SHALL asynchronously force phase=0, pointers=0, level=0, dout_vld=0, ovf=0, and dout=0.
REQ-026 Reset mid-operation SHALL discard all buffered samples; the first kept sample after release is the DECIM-th valid sample.
REQ-027 FIFO storage array is not reset; dout SHALL read 0 whenever level==0.

Structure
REQ-028 A shared package lpf_pkg SHALL hold the DW default, the DECIM/DEPTH defaults, and a level-width function.
REQ-029 Storage and pointer logic SHALL reside in one sub-module, sync_fifo_fwft (DW, DEPTH), which takes push/pop/din and provides dout/empty/full/level; decimation and overflow logic sit in the top level.

Verification
REQ-030 DECIM=2, din_vld=1, din ramps 0,5,10,... one step per clock, dout_rdy=1 -> dout sequence 5,15,25,35, dout_vld high every other cycle, level<=1.
REQ-031 DECIM=2, dout_rdy=0 for 20 valid cycles from reset -> level reaches 8 after the 16th cycle, 9th kept sample dropped, ovf=1; then dout_rdy=1 -> drains 5,15,...,75 in order.
REQ-032 Full FIFO, dout_rdy=1 on the exact cycle of a push -> level stays 8, ovf stays 0, no sample lost.
REQ-033 din_vld toggling 1,0,1,0 with DECIM=2 -> phase advances only on valid cycles; kept samples are every 2nd valid one.
REQ-034 rst_n pulsed low for 3 ns mid-burst with level=5 -> immediately level=0, dout_vld=0, ovf=0; after release, the first output is the 2nd valid sample.
REQ-035 ovf=1, ovf_clr=1 asserted while a drop occurs -> ovf stays 1; ovf_clr on the next idle cycle -> ovf=0.
